dispatch_ctrl: RTL and testbench
================================

# dispatch_ctrl

Single-slot dispatch controller between the decode stage and the three function-unit reservation stations (ALU, LSQ, BRA) of the out-of-order core. It accepts one decoded instruction per cycle over a valid/ready handshake and allocates a ROB tag for it. It then holds the instruction in an output register until the reservation station selected by the decoded FU type accepts it. It also tracks ROB occupancy from allocation and commit, and recovers on pipeline flush.

## Interface
Parameters:
- ROB_DEPTH, 16, ROB entries; power of two, ≥2
- TAG_W, 4, log2(ROB_DEPTH)
- PAYLOAD_W, 64, opaque decoded-instruction bundle, passed through unmodified

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush (mispredict/exception), synchronous level
- dec_valid  in  1  decode stage offers an instruction
- dec_ready  out  1  dispatch accepts this cycle
- dec_futype  in  3  FU type from decoder (`FU_ALU / `FU_LSQ / `FU_BRA; anything else invalid)
- dec_rob_we  in  1  decoder ROBWrite_en (valid instruction)
- dec_payload  in  PAYLOAD_W  instruction bundle
- alu_valid / lsq_valid / bra_valid  out  1 each  slot offered to that unit; at most one high
- alu_ready / lsq_ready / bra_ready  in  1 each  unit accepts
- disp_payload  out  PAYLOAD_W  held bundle
- disp_tag  out  TAG_W  ROB tag of held bundle
- rob_alloc  out  1  combinational pulse: ROB entry allocated this cycle
- rob_alloc_tag  out  TAG_W  tag being allocated (= tail pointer)
- rob_commit  in  1  ROB retired one entry this cycle
- rob_count  out  TAG_W+1  occupied ROB entries, 0..ROB_DEPTH
- illegal  out  1  registered one-cycle pulse: invalid instruction dropped

## Operation
- State machine, encoded in 2 bits:
  - IDLE: slot empty.
  - HOLD: slot full, waiting for the target unit.
  - RECOVER: one cycle after a flush; accepts nothing.
- sel_ready = ready input of the unit matching the held FU type.
- rob_space = (rob_count < ROB_DEPTH). A commit in the same cycle does not create space; there is no bypass.
- dec_ready = !flush && rob_space && (IDLE || (HOLD && sel_ready)). It must not depend on dec_valid or payload inputs.
- Accept = dec_valid && dec_ready.
- inst_ok = dec_rob_we && dec_futype ∈ {`FU_ALU, `FU_LSQ, `FU_BRA}.
- Accept with inst_ok:
  - Assert rob_alloc and present rob_alloc_tag = tail.
  - Load payload, futype and tag into the slot.
  - tail ← tail+1 mod ROB_DEPTH; next state HOLD.
- Accept with !inst_ok: no allocation and no slot load; illegal pulses next cycle; slot drains normally if it was in HOLD.
- HOLD: the matching unit's valid is high. On sel_ready the slot is consumed, giving next state HOLD if a new accept happens in the same cycle, else IDLE.
- Count update: rob_count ← rob_count + rob_alloc − (rob_commit && rob_count≠0). A commit at count 0 is ignored. Alloc and commit together leave the count unchanged.
- flush (priority over everything):
  - Slot cleared, all unit valids low next cycle.
  - tail ← 0, rob_count ← 0.
  - rob_alloc and dec_ready forced 0 in the flush cycle.
  - Next state RECOVER; RECOVER → IDLE unconditionally.
  - Flush while in RECOVER extends RECOVER.
- The held payload and tag stay stable while in HOLD and the unit is not ready.

## Timing
- Reset (async assert) sets: state IDLE, tail 0, rob_count 0, all unit valids 0, illegal 0, disp_payload/disp_tag 0. dec_ready = 1 once rst_n deasserts, because it is combinational from state.
- Latency: the instruction accepted in cycle N has its unit valid high in N+1.
- Throughput: 1 instruction/cycle while the target is ready and the ROB is not full.
- A full ROB stalls dec_ready. It reasserts the cycle after the count drops below ROB_DEPTH.
- Wrap-around: the tag after ROB_DEPTH−1 is 0.
- rob_alloc and rob_alloc_tag are combinational in the accept cycle. illegal is registered (N+1).

## Test plan
- Reset, then 3 back-to-back accepts (ALU, LSQ, BRA), all units ready:
  - tags 0, 1, 2;
  - alu_valid, lsq_valid, bra_valid each high in cycles 1, 2, 3;
  - rob_count reaches 3.
- ALU op held with alu_ready=0 for 4 cycles:
  - alu_valid stays high; payload and tag stable; dec_ready=0.
  - alu_ready=1 with a new dec_valid → same-cycle consume and accept, state stays HOLD.
- Fill ROB_DEPTH=16 with no commits: 16th accept gets tag 15, rob_count=16, dec_ready=0. One commit → count 15, dec_ready=1 next cycle; the next tag is 0 (wrap).
- dec_rob_we=0 (or dec_futype=0):
  - accepted with no rob_alloc;
  - illegal pulses one cycle;
  - rob_count and tail unchanged, no unit valid.
- Flush while in HOLD with rob_count=5:
  - next cycle all valids 0, rob_count=0;
  - RECOVER holds dec_ready=0 for one cycle;
  - the next accept gets tag 0.
- rst_n dropped mid-HOLD asynchronously → all outputs return to reset values without waiting for a clock edge; rob_commit at count 0 leaves the count at 0.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// Single-slot dispatch controller: accepts decoded instructions, allocates ROB tags,
// and holds each instruction until its target reservation station takes it.
`ifndef FU_ALU
`define FU_ALU 3'd1
`endif
`ifndef FU_LSQ
`define FU_LSQ 3'd2
`endif
`ifndef FU_BRA
`define FU_BRA 3'd3
`endif

module dispatch_ctrl #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 4,
    parameter int PAYLOAD_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [2:0]           dec_futype,
    input  logic                 dec_rob_we,
    input  logic [PAYLOAD_W-1:0] dec_payload,
    output logic                 alu_valid,
    output logic                 lsq_valid,
    output logic                 bra_valid,
    input  logic                 alu_ready,
    input  logic                 lsq_ready,
    input  logic                 bra_ready,
    output logic [PAYLOAD_W-1:0] disp_payload,
    output logic [TAG_W-1:0]     disp_tag,
    output logic                 rob_alloc,
    output logic [TAG_W-1:0]     rob_alloc_tag,
    input  logic                 rob_commit,
    output logic [TAG_W:0]       rob_count,
    output logic                 illegal
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic [TAG_W:0] ROB_FULL = (TAG_W+1)'(ROB_DEPTH);

    state_t           state;
    logic [2:0]       fu_q;
    logic [TAG_W-1:0] tail;
    logic             sel_ready;
    logic             rob_space;
    logic             accept;
    logic             inst_ok;
    logic             commit_eff;
    logic [TAG_W:0]   count_nxt;

    always_comb begin
        sel_ready = 1'b0;
        case (fu_q)
            `FU_ALU: sel_ready = alu_ready;
            `FU_LSQ: sel_ready = lsq_ready;
            `FU_BRA: sel_ready = bra_ready;
            default: sel_ready = 1'b0;
        endcase
    end

    // A same-cycle commit never frees space for this cycle's accept.
    assign rob_space = (rob_count < ROB_FULL);
    assign dec_ready = !flush && rob_space &&
                       ((state == IDLE) || ((state == HOLD) && sel_ready));
    assign accept    = dec_valid && dec_ready;
    assign inst_ok   = dec_rob_we && ((dec_futype == `FU_ALU) ||
                                      (dec_futype == `FU_LSQ) ||
                                      (dec_futype == `FU_BRA));
    assign rob_alloc     = accept && inst_ok;
    assign rob_alloc_tag = tail;

    assign commit_eff = rob_commit && (rob_count != '0);
    assign count_nxt  = rob_count + {{TAG_W{1'b0}}, rob_alloc}
                                  - {{TAG_W{1'b0}}, commit_eff};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            fu_q         <= 3'd0;
            tail         <= '0;
            rob_count    <= '0;
            alu_valid    <= 1'b0;
            lsq_valid    <= 1'b0;
            bra_valid    <= 1'b0;
            illegal      <= 1'b0;
            disp_payload <= '0;
            disp_tag     <= '0;
        end else if (flush) begin
            state     <= RECOVER;
            tail      <= '0;
            rob_count <= '0;
            alu_valid <= 1'b0;
            lsq_valid <= 1'b0;
            bra_valid <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            illegal   <= accept && !inst_ok;
            rob_count <= count_nxt;
            // Allocation only happens from IDLE or a draining HOLD, so it covers both.
            if (rob_alloc) begin
                disp_payload <= dec_payload;
                disp_tag     <= tail;
                fu_q         <= dec_futype;
                alu_valid    <= (dec_futype == `FU_ALU);
                lsq_valid    <= (dec_futype == `FU_LSQ);
                bra_valid    <= (dec_futype == `FU_BRA);
                tail         <= tail + TAG_W'(1);
                state        <= HOLD;
            end else if ((state == HOLD) && sel_ready) begin
                alu_valid <= 1'b0;
                lsq_valid <= 1'b0;
                bra_valid <= 1'b0;
                state     <= IDLE;
            end else if (state == RECOVER) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: handshake, ROB tag allocation, stalls, flush and reset.
`ifndef FU_ALU
`define FU_ALU 3'd1
`endif
`ifndef FU_LSQ
`define FU_LSQ 3'd2
`endif
`ifndef FU_BRA
`define FU_BRA 3'd3
`endif

module tb_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic [2:0]  dec_futype = 3'd0;
    logic        dec_rob_we = 1'b0;
    logic [63:0] dec_payload = 64'd0;
    logic        alu_valid, lsq_valid, bra_valid;
    logic        alu_ready = 1'b1;
    logic        lsq_ready = 1'b1;
    logic        bra_ready = 1'b1;
    logic [63:0] disp_payload;
    logic [3:0]  disp_tag;
    logic        rob_alloc;
    logic [3:0]  rob_alloc_tag;
    logic        rob_commit = 1'b0;
    logic [4:0]  rob_count;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    dispatch_ctrl #(.ROB_DEPTH(16), .TAG_W(4), .PAYLOAD_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_futype(dec_futype),
        .dec_rob_we(dec_rob_we), .dec_payload(dec_payload),
        .alu_valid(alu_valid), .lsq_valid(lsq_valid), .bra_valid(bra_valid),
        .alu_ready(alu_ready), .lsq_ready(lsq_ready), .bra_ready(bra_ready),
        .disp_payload(disp_payload), .disp_tag(disp_tag),
        .rob_alloc(rob_alloc), .rob_alloc_tag(rob_alloc_tag),
        .rob_commit(rob_commit), .rob_count(rob_count), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] fu, input logic we, input logic [63:0] p);
        dec_valid   = v;
        dec_futype  = fu;
        dec_rob_we  = we;
        dec_payload = p;
    endtask

    task automatic chk_valids(input string tag, input logic a, input logic l, input logic b);
        chk({tag, "_alu"}, alu_valid, a);
        chk({tag, "_lsq"}, lsq_valid, l);
        chk({tag, "_bra"}, bra_valid, b);
    endtask

    initial begin
        // Reset
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_count", rob_count, 0);
        chk_valids("rst", 0, 0, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_tag", disp_tag, 0);
        chk("rst_payload", disp_payload, 0);
        #2 rst_n = 1'b1;
        #1 chk("rst_ready", dec_ready, 1);

        // Back-to-back ALU, LSQ, BRA with all units ready
        tick();
        drive(1, `FU_ALU, 1, 64'hA0A0);
        #1 chk("b2b0_alloc", rob_alloc, 1);
        chk("b2b0_tag", rob_alloc_tag, 0);
        tick();
        chk_valids("b2b1", 1, 0, 0);
        chk("b2b1_dtag", disp_tag, 0);
        chk("b2b1_pay", disp_payload, 64'hA0A0);
        drive(1, `FU_LSQ, 1, 64'hB0B0);
        #1 chk("b2b1_ready", dec_ready, 1);
        chk("b2b1_tag", rob_alloc_tag, 1);
        tick();
        chk_valids("b2b2", 0, 1, 0);
        chk("b2b2_dtag", disp_tag, 1);
        drive(1, `FU_BRA, 1, 64'hC0C0);
        tick();
        chk_valids("b2b3", 0, 0, 1);
        chk("b2b3_dtag", disp_tag, 2);
        chk("b2b3_count", rob_count, 3);
        drive(0, 3'd0, 0, 0);
        tick();
        chk_valids("b2b_drain", 0, 0, 0);
        chk("b2b_drain_count", rob_count, 3);

        // ALU held while unit not ready
        alu_ready = 1'b0;
        drive(1, `FU_ALU, 1, 64'hD0D0);
        tick();
        chk("hold_count", rob_count, 4);
        drive(1, `FU_ALU, 1, 64'hE0E0);
        for (int i = 0; i < 4; i++) begin
            #1 chk("hold_ready", dec_ready, 0);
            chk("hold_alloc", rob_alloc, 0);
            chk("hold_valid", alu_valid, 1);
            chk("hold_pay", disp_payload, 64'hD0D0);
            chk("hold_tag", disp_tag, 3);
            tick();
        end
        alu_ready = 1'b1;
        drive(1, `FU_LSQ, 1, 64'hE0E0);
        #1 chk("swap_ready", dec_ready, 1);
        chk("swap_tag", rob_alloc_tag, 4);
        tick();
        chk_valids("swap", 0, 1, 0);
        chk("swap_dtag", disp_tag, 4);
        chk("swap_pay", disp_payload, 64'hE0E0);
        chk("swap_count", rob_count, 5);
        drive(0, 3'd0, 0, 0);
        tick();

        // Flush in HOLD at count 5 (alloc and commit in the same cycle keep count)
        alu_ready  = 1'b0;
        rob_commit = 1'b1;
        drive(1, `FU_ALU, 1, 64'hF0F0);
        tick();
        rob_commit = 1'b0;
        chk("fl_pre_count", rob_count, 5);
        chk("fl_pre_valid", alu_valid, 1);
        flush = 1'b1;
        alu_ready = 1'b1;
        #1 chk("fl_ready", dec_ready, 0);
        chk("fl_alloc", rob_alloc, 0);
        tick();
        flush = 1'b0;
        chk_valids("fl_post", 0, 0, 0);
        chk("fl_post_count", rob_count, 0);
        #1 chk("rec_ready", dec_ready, 0);
        tick();
        #1 chk("rec_done_ready", dec_ready, 1);
        chk("rec_done_tag", rob_alloc_tag, 0);
        tick();
        chk("rec_acc_dtag", disp_tag, 0);
        chk("rec_acc_count", rob_count, 1);
        drive(0, 3'd0, 0, 0);
        tick();

        // Invalid instructions: dropped, illegal pulses
        drive(1, `FU_ALU, 0, 64'h1111);
        #1 chk("ill_we_alloc", rob_alloc, 0);
        chk("ill_we_ready", dec_ready, 1);
        tick();
        chk("ill_we_pulse", illegal, 1);
        chk_valids("ill_we", 0, 0, 0);
        chk("ill_we_count", rob_count, 1);
        drive(0, 3'd0, 0, 0);
        tick();
        chk("ill_we_clear", illegal, 0);
        drive(1, 3'd0, 1, 64'h2222);
        #1 chk("ill_fu_alloc", rob_alloc, 0);
        tick();
        chk("ill_fu_pulse", illegal, 1);
        chk_valids("ill_fu", 0, 0, 0);
        drive(0, 3'd0, 0, 0);
        tick();
        chk("ill_fu_clear", illegal, 0);
        chk("ill_tail", rob_alloc_tag, 1);
        chk("ill_count", rob_count, 1);

        // Fill the ROB from empty, then commit one and wrap the tag
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        drive(1, `FU_ALU, 1, 64'h5555);
        for (int i = 0; i < 16; i++) begin
            #1 chk("fill_tag", rob_alloc_tag, i);
            tick();
        end
        chk("full_dtag", disp_tag, 15);
        chk("full_count", rob_count, 16);
        #1 chk("full_ready", dec_ready, 0);
        chk("full_alloc", rob_alloc, 0);
        rob_commit = 1'b1;
        tick();
        rob_commit = 1'b0;
        chk("cm_count", rob_count, 15);
        #1 chk("cm_ready", dec_ready, 1);
        chk("wrap_tag", rob_alloc_tag, 0);
        tick();
        chk("wrap_dtag", disp_tag, 0);
        chk("wrap_count", rob_count, 16);
        drive(0, 3'd0, 0, 0);

        // Asynchronous reset mid-HOLD
        alu_ready = 1'b0;
        tick();
        chk("ar_pre_valid", alu_valid, 1);
        #1 rst_n = 1'b0;
        #1 chk("ar_count", rob_count, 0);
        chk_valids("ar", 0, 0, 0);
        chk("ar_tag", disp_tag, 0);
        chk("ar_pay", disp_payload, 0);
        chk("ar_illegal", illegal, 0);
        chk("ar_alloc_tag", rob_alloc_tag, 0);
        tick();
        rst_n = 1'b1;
        rob_commit = 1'b1;
        #1 chk("ar_ready", dec_ready, 1);
        tick();
        rob_commit = 1'b0;
        chk("commit0_count", rob_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
